fanout_broadcast: RTL and testbench
===================================

FANOUT_BROADCAST -- requirements
Module: fanout_broadcast

Interface
REQ-001 SHALL have parameter NUM_OUT, default 4: number of downstream consumers (2..8).
REQ-002 SHALL have parameter DATA_W, default 16: payload width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, DATA_W: upstream payload.
REQ-006 SHALL have port in_valid, input, 1: upstream payload valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts in_data this cycle.
REQ-008 SHALL have port en, input, NUM_OUT: per-consumer enable mask, static or changing only between tokens.
REQ-009 SHALL have port out_data, output, NUM_OUT*DATA_W: per-consumer payload, slice i for consumer i.
REQ-010 SHALL have port out_valid, output, NUM_OUT: per-consumer valid.
REQ-011 SHALL have port out_ready, input, NUM_OUT: per-consumer ready.

Function
REQ-012 SHALL hold one token in a holding register with full flag; FSM states EMPTY (full=0) and HOLD (full=1).
REQ-013 SHALL load on in_valid & in_ready: data into the holding register, en into the pending mask pend[NUM_OUT].
REQ-014 SHALL drive every out_data slice from the holding register, never combinationally from in_data.
REQ-015 SHALL drive out_valid[i] = full & pend[i].
REQ-016 SHALL clear pend[i] on the edge where out_valid[i] & out_ready[i]; each consumer receives each token exactly once.
REQ-017 SHALL define retire = full & ((pend & ~(out_valid & out_ready)) == 0); on retire, full clears unless a new token loads on the same edge.
REQ-018 SHALL drive in_ready = ~full | retire, allowing back-to-back tokens at one per cycle when all enabled consumers are ready.
REQ-019 SHALL accept and silently drop a token loaded with en == 0: it enters HOLD with pend = 0, retires on the next cycle and raises no out_valid.
REQ-020 SHALL, on simultaneous retire and load, replace the data and set pend = en on the same edge, with no bubble cycle.
REQ-021 SHALL ignore changes of en while in HOLD; the pending mask of the current token is fixed at load.
REQ-022 SHALL have latency of one cycle from in handshake to out_valid.
REQ-023 SHALL never deassert out_valid[i] before its handshake, and out_data SHALL stay stable while any out_valid is high.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear full, pend and the holding register, and SHALL return to EMPTY.
REQ-025 SHALL, during reset and in EMPTY, drive in_ready = 1 and out_valid = 0; a mid-token reset discards the token.
REQ-026 SHALL release reset without a spurious handshake on the first active edge.

Configuration
REQ-027 SHALL, when macro FANOUT_BROADCAST_STALL_CNT_EN is defined, add output stall_cnt[15:0]: it increments each cycle with full & ~retire, saturates at 0xFFFF, and resets to 0 on rst_n.
REQ-028 SHALL, without FANOUT_BROADCAST_STALL_CNT_EN, have no stall_cnt port or logic, and SHALL leave all other behaviour identical.

Verification
REQ-029 SHALL cover broadcast: NUM_OUT=4, en=4'b1111, all out_ready=1, send 0x0001..0x0008 back-to-back -> each consumer sees 8 tokens in order, in_ready stays 1, one token per cycle.
REQ-030 SHALL cover staggered accept: en=4'b1011, token 0xABCD, out_ready[0] high at cycle 1, [1] at 3, [3] at 5 -> out_valid[2] never high, in_ready low cycles 1-4, high at cycle 5.
REQ-031 SHALL cover mask drop: en=0, token 0x1234 -> no out_valid, in_ready low at most one cycle, next token 0x5678 with en=4'b0001 delivered to consumer 0 only.
REQ-032 SHALL cover the mid-HOLD mask change: load with en=4'b0011, switch en to 4'b1100 before accept -> only consumers 0 and 1 receive the token; the next token goes to 2 and 3.
REQ-033 SHALL cover reset mid-operation: rst_n low while pend=4'b0100 -> out_valid=0 and in_ready=1 immediately, no delivery after release, stall_cnt=0 if enabled.
REQ-034 SHALL cover the stall counter: with FANOUT_BROADCAST_STALL_CNT_EN, hold out_ready=0 for 70000 cycles with a token pending -> stall_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/fanout_broadcast.sv
// ============================================================================
// Module   : fanout_broadcast
// Purpose  : One-token holding register broadcast to NUM_OUT consumers. Each
//            enabled consumer takes the token exactly once. Optional stall
//            counter output is built when FANOUT_BROADCAST_STALL_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fanout_broadcast #(
  parameter int NUM_OUT = 4,
  parameter int DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_OUT-1:0]          en,
  output logic [NUM_OUT*DATA_W-1:0]   out_data,
  output logic [NUM_OUT-1:0]          out_valid,
`ifdef FANOUT_BROADCAST_STALL_CNT_EN
  output logic [15:0]                 stall_cnt,
`endif
  input  logic [NUM_OUT-1:0]          out_ready
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_OUT-1:0] pend_q, pend_d;

  logic               full;
  logic               retire;
  logic               load;
  logic [NUM_OUT-1:0] hs;

  assign full   = (state_q == S_HOLD);
  assign hs     = out_valid & out_ready;
  // A token retires once every still-pending consumer handshakes this cycle.
  assign retire = full & ((pend_q & ~hs) == '0);
  assign load   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load) state_d = S_HOLD;
      S_HOLD: begin
        if (load)        state_d = S_HOLD;
        else if (retire) state_d = S_EMPTY;
      end
      default:           state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = ~full | retire;
    out_valid = {NUM_OUT{full}} & pend_q;
  end

  // en is sampled only at load, so mask changes during HOLD have no effect.
  always_comb begin
    data_d = data_q;
    pend_d = pend_q & ~hs;
    if (load) begin
      data_d = in_data;
      pend_d = en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      pend_q <= '0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign out_data = {NUM_OUT{data_q}};

`ifdef FANOUT_BROADCAST_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (full && !retire && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fanout_broadcast.sv
// ============================================================================
// Module   : tb_fanout_broadcast
// Purpose  : Directed self-checking bench for fanout_broadcast (NUM_OUT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fanout_broadcast;

  localparam int NUM_OUT = 4;
  localparam int DATA_W  = 16;

  logic                      clk;
  logic                      rst_n;
  logic [DATA_W-1:0]         in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_OUT-1:0]        en;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
`ifdef FANOUT_BROADCAST_STALL_CNT_EN
  logic [15:0]               stall_cnt;
`endif

  int checks;
  int failures;

  fanout_broadcast #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en        (en),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef FANOUT_BROADCAST_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven on the falling edge; outputs are checked #1 later.
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; en = '0; out_ready = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs in_ready=%b out_valid=%b exp 1/0000", in_ready, out_valid);
    end
    checks++;
    if (out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", out_data);
    end
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_data = 16'hDEAD; en = 4'b1111;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release out_valid=%b in_ready=%b exp 0000/1", out_valid, in_ready);
    end
  endtask

  task automatic test_broadcast();
    logic [63:0] exp;
    en = 4'b1111; out_ready = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k > 1) begin
        exp = {4{16'(k - 1)}};
        checks++;
        if (out_valid !== 4'b1111 || out_data !== exp) begin
          failures++;
          $display("FAIL bcast_tok%0d out_valid=%b data=%h exp 1111/%h", k - 1, out_valid, out_data, exp);
        end
      end
      in_data = 16'(k); in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL bcast_in_ready_%0d got=%b exp=1", k, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b1111 || out_data !== {4{16'h0008}}) begin
      failures++;
      $display("FAIL bcast_tok8 out_valid=%b data=%h exp 1111/0008x4", out_valid, out_data);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bcast_drain out_valid=%b in_ready=%b exp 0000/1", out_valid, in_ready);
    end
  endtask

  task automatic test_staggered();
    logic [3:0] exp_v [1:6];
    logic [3:0] rdy   [1:6];
    exp_v[1] = 4'b1011; exp_v[2] = 4'b1010; exp_v[3] = 4'b1010;
    exp_v[4] = 4'b1000; exp_v[5] = 4'b1000; exp_v[6] = 4'b0000;
    rdy[1] = 4'b0001; rdy[2] = 4'b0000; rdy[3] = 4'b0010;
    rdy[4] = 4'b0000; rdy[5] = 4'b1000; rdy[6] = 4'b0000;
    @(negedge clk);
    en = 4'b1011; out_ready = 4'b0000; in_data = 16'hABCD; in_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = rdy[c];
      #1;
      checks++;
      if (out_valid !== exp_v[c] || in_ready !== (c >= 5)) begin
        failures++;
        $display("FAIL stagger_c%0d out_valid=%b in_ready=%b exp %b/%b", c, out_valid, in_ready, exp_v[c], (c >= 5));
      end
      if (c <= 5) begin
        checks++;
        if (out_data[15:0] !== 16'hABCD) begin
          failures++;
          $display("FAIL stagger_data_c%0d got=%h exp=abcd", c, out_data[15:0]);
        end
      end
    end
  endtask

  task automatic test_mask_drop();
    @(negedge clk);
    en = 4'b0000; out_ready = 4'b0000; in_data = 16'h1234; in_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drop_hold out_valid=%b in_ready=%b exp 0000/1", out_valid, in_ready);
    end
    en = 4'b0001; in_data = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0001 || out_data[15:0] !== 16'h5678) begin
      failures++;
      $display("FAIL drop_next out_valid=%b data=%h exp 0001/5678", out_valid, out_data[15:0]);
    end
    out_ready = 4'b0001;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drop_done out_valid=%b in_ready=%b exp 0000/1", out_valid, in_ready);
    end
  endtask

  task automatic test_mask_change();
    @(negedge clk);
    en = 4'b0011; out_ready = 4'b0000; in_data = 16'hAAAA; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; en = 4'b1100;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 4'b0011 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mchg_hold out_valid=%b in_ready=%b exp 0011/0", out_valid, in_ready);
    end
    out_ready = 4'b1111;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL mchg_retire out_valid=%b exp=0000", out_valid);
    end
    in_data = 16'hBBBB; in_valid = 1'b1; out_ready = 4'b0000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b1100 || out_data[63:48] !== 16'hBBBB || out_data[47:32] !== 16'hBBBB) begin
      failures++;
      $display("FAIL mchg_next out_valid=%b data=%h exp 1100/bbbb", out_valid, out_data);
    end
    out_ready = 4'b1100;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mchg_done out_valid=%b in_ready=%b exp 0000/1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    en = 4'b0100; out_ready = 4'b0000; in_data = 16'hCCCC; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0100) begin
      failures++;
      $display("FAIL mrst_pend out_valid=%b exp=0100", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mrst_async out_valid=%b in_ready=%b exp 0000/1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 4'b1111;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1 || out_data !== 64'h0) begin
      failures++;
      $display("FAIL mrst_after out_valid=%b in_ready=%b data=%h exp 0000/1/0", out_valid, in_ready, out_data);
    end
`ifdef FANOUT_BROADCAST_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'h0) begin
      failures++;
      $display("FAIL mrst_stall got=%h exp=0", stall_cnt);
    end
`endif
  endtask

`ifdef FANOUT_BROADCAST_STALL_CNT_EN
  task automatic test_stall_cnt();
    @(negedge clk);
    en = 4'b0001; out_ready = 4'b0000; in_data = 16'h7777; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stall_count got=%h exp=0003", stall_cnt);
    end
    repeat (70000) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_sat got=%h exp=ffff", stall_cnt);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_broadcast();
    test_staggered();
    test_mask_drop();
    test_mask_change();
    test_mid_reset();
`ifdef FANOUT_BROADCAST_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
